// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexes eight active-low 7-segment patterns onto
// one shared segment bus plus an active-low digit-select bus.
//
// Scan order: digits are shown round-robin. Each enabled digit gets a
// blanking gap first, then its show time. Masked digits are skipped.
//
// Optional feature: define SEG_SCAN_DIM_EN to add the 4-bit 'dim' input.
// It PWM-dims the digit select during SHOW.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16,
    parameter int CNT_W     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  digit_mask,
    input  logic [63:0] seg_in,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]  dim,
`endif
    output logic [7:0]  seg_out,
    output logic [7:0]  an_out,
    output logic [2:0]  cur_digit,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);

    // Result bit 3 is the wrap flag and bits 2:0 are the digit index.
    // The function looks for the lowest set mask bit strictly above cur.
    // If there is none, it wraps to the lowest set bit and sets the wrap flag.
    // An all-zero mask must be handled by the caller.
    function automatic logic [3:0] pick_next(input logic [7:0] mask,
                                             input logic [2:0] cur);
        logic [2:0] idx;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 7; i >= 0; i--) begin
                if (mask[i]) begin
                    idx = 3'(i);
                end
            end
        end
        return {~found, idx};
    endfunction

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]      seg_out_q;
    logic [7:0]      an_out_q;
    logic [2:0]      cur_digit_q;
    logic            frame_tick_q;

    logic [3:0]      next_sel_d;
    logic [3:0]      first_sel_d;
    logic [7:0]      an_sel_d;
    logic [7:0]      seg_slice_d;

    // Decode the next digit to scan and the pattern and select of the current digit.
    always_comb begin
        next_sel_d  = pick_next(digit_mask, cur_digit_q);
        first_sel_d = pick_next(digit_mask, 3'd7);
        an_sel_d    = ~(8'd1 << cur_digit_q);
        seg_slice_d = seg_in[{cur_digit_q, 3'b000} +: 8];
    end

`ifdef SEG_SCAN_DIM_EN
    logic [3:0] phase_q;
    logic [3:0] phase_inc_d;

    // Compute the PWM phase that the next SHOW cycle will see.
    always_comb begin
        phase_inc_d = phase_q + 4'd1;
    end
`endif

    // Scan sequencer: IDLE -> BLANK -> SHOW -> BLANK ..., with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            seg_out_q    <= 8'hFF;
            an_out_q     <= 8'hFF;
            cur_digit_q  <= 3'd0;
            frame_tick_q <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
            phase_q      <= 4'd0;
`endif
        end else if (!en) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            seg_out_q    <= 8'hFF;
            an_out_q     <= 8'hFF;
            frame_tick_q <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
            phase_q      <= 4'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    seg_out_q    <= 8'hFF;
                    an_out_q     <= 8'hFF;
                    frame_tick_q <= 1'b0;
                    cnt_q        <= '0;
                    if (digit_mask != 8'h00) begin
                        cur_digit_q <= first_sel_d[2:0];
                        state_q     <= ST_BLANK;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_BLANK: begin
                    frame_tick_q <= 1'b0;
                    if (cnt_q == BLANK_LAST) begin
                        // Freeze this digit's pattern for its whole SHOW.
                        cnt_q     <= '0;
                        seg_out_q <= seg_slice_d;
                        an_out_q  <= an_sel_d;
                        state_q   <= ST_SHOW;
`ifdef SEG_SCAN_DIM_EN
                        phase_q   <= 4'd0;
`endif
                    end else begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        seg_out_q <= 8'hFF;
                        an_out_q  <= 8'hFF;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_q     <= '0;
                        seg_out_q <= 8'hFF;
                        an_out_q  <= 8'hFF;
                        if (digit_mask == 8'h00) begin
                            frame_tick_q <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            cur_digit_q  <= next_sel_d[2:0];
                            frame_tick_q <= next_sel_d[3];
                            state_q      <= ST_BLANK;
                        end
                    end else begin
                        cnt_q        <= cnt_q + CNT_W'(1);
                        frame_tick_q <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
                        phase_q      <= phase_inc_d;
                        an_out_q     <= (phase_inc_d <= dim) ? an_sel_d : 8'hFF;
`endif
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    cnt_q        <= '0;
                    seg_out_q    <= 8'hFF;
                    an_out_q     <= 8'hFF;
                    frame_tick_q <= 1'b0;
                end
            endcase
        end
    end

    assign seg_out    = seg_out_q;
    assign an_out     = an_out_q;
    assign cur_digit  = cur_digit_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SCAN_DIV=4, BLANK_CYC=2, default build).
module tb_seg_scan_ctrl;

    localparam int SD = 4;
    localparam int BC = 2;
    localparam int DP = SD + BC;
    localparam logic [31:0] CARE_ALL   = 32'hFFFF_FFFF;
    localparam logic [31:0] CARE_NOCUR = 32'hFFFF_F8FF;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  digit_mask;
    logic [63:0] seg_in;
    logic [7:0]  seg_out;
    logic [7:0]  an_out;
    logic [2:0]  cur_digit;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .digit_mask (digit_mask),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .cur_digit  (cur_digit),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] mask;
        int         k;
        logic [7:0] seg;
        logic [7:0] an;
        logic [2:0] cur;
        logic       ft;
    } vec_t;

    function automatic logic [31:0] pk(input logic [7:0] s, input logic [7:0] a,
                                       input logic [2:0] c, input logic t);
        return {s, a, 5'd0, c, 7'd0, t};
    endfunction

    function automatic logic [31:0] obs();
        return pk(seg_out, an_out, cur_digit, frame_tick);
    endfunction

    task automatic chk(input string nm, input logic [31:0] exp, input logic [31:0] care);
        logic [31:0] got;
        got = obs();
        n_tests++;
        if ((got & care) !== (exp & care)) begin
            n_fail++;
            $display("FAIL %s: got seg/an/cur/ft=%h required %h (care %h)", nm, got, exp, care);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Park the DUT in IDLE, then enable it with mask m. Afterwards the bench
    // sits at scan cycle k=0, right after the first edge out of IDLE.
    task automatic start(input logic [7:0] m);
        en = 1'b0;
        step(1);
        digit_mask = m;
        en = 1'b1;
        step(1);
    endtask

    // Reference: the expected outputs k cycles after leaving IDLE. The model
    // builds the digit order from the mask and takes frame position k mod period.
    function automatic logic [31:0] model(input logic [7:0] m, input logic [63:0] s, input int k);
        int order[$];
        int p, r, d, ph;
        logic t;
        for (int i = 0; i < 8; i++) if (m[i]) order.push_back(i);
        if (order.size() == 0) return pk(8'hFF, 8'hFF, 3'd0, 1'b0);
        p  = order.size() * DP;
        r  = k % p;
        d  = order[r / DP];
        ph = r % DP;
        t  = (k >= p) && (r == 0);
        if (ph < BC) return pk(8'hFF, 8'hFF, 3'(d), t);
        return pk(s[8*d +: 8], ~(8'h01 << d), 3'(d), 1'b0);
    endfunction

    logic [63:0] seg_def;
    vec_t        vecs[$];

    initial begin
        for (int i = 0; i < 8; i++) seg_def[8*i +: 8] = 8'h10 + 8'(i);

        // Directed vectors. k counts cycles after the enable edge.
        vecs.push_back('{8'hFF,  0, 8'hFF, 8'hFF, 3'd0, 1'b0});
        vecs.push_back('{8'hFF,  1, 8'hFF, 8'hFF, 3'd0, 1'b0});
        vecs.push_back('{8'hFF,  2, 8'h10, 8'hFE, 3'd0, 1'b0});
        vecs.push_back('{8'hFF,  5, 8'h10, 8'hFE, 3'd0, 1'b0});
        vecs.push_back('{8'hFF,  6, 8'hFF, 8'hFF, 3'd1, 1'b0});
        vecs.push_back('{8'hFF,  8, 8'h11, 8'hFD, 3'd1, 1'b0});
        vecs.push_back('{8'hFF, 44, 8'h17, 8'h7F, 3'd7, 1'b0});
        vecs.push_back('{8'hFF, 47, 8'h17, 8'h7F, 3'd7, 1'b0});
        vecs.push_back('{8'hFF, 48, 8'hFF, 8'hFF, 3'd0, 1'b1});
        vecs.push_back('{8'hFF, 49, 8'hFF, 8'hFF, 3'd0, 1'b0});
        vecs.push_back('{8'hFF, 96, 8'hFF, 8'hFF, 3'd0, 1'b1});
        vecs.push_back('{8'h85,  8, 8'h12, 8'hFB, 3'd2, 1'b0});
        vecs.push_back('{8'h85, 14, 8'h17, 8'h7F, 3'd7, 1'b0});
        vecs.push_back('{8'h85, 18, 8'hFF, 8'hFF, 3'd0, 1'b1});
        vecs.push_back('{8'h85, 20, 8'h10, 8'hFE, 3'd0, 1'b0});
        vecs.push_back('{8'h85, 26, 8'h12, 8'hFB, 3'd2, 1'b0});
        vecs.push_back('{8'h20,  0, 8'hFF, 8'hFF, 3'd5, 1'b0});
        vecs.push_back('{8'h20,  2, 8'h15, 8'hDF, 3'd5, 1'b0});
        vecs.push_back('{8'h20,  6, 8'hFF, 8'hFF, 3'd5, 1'b1});
        vecs.push_back('{8'h20, 12, 8'hFF, 8'hFF, 3'd5, 1'b1});

        reset      = 1'b0;
        en         = 1'b0;
        digit_mask = 8'hFF;
        seg_in     = seg_def;

        // Reset state, then release with en=0: outputs stay idle.
        #12;
        chk("reset_vals", pk(8'hFF, 8'hFF, 3'd0, 1'b0), CARE_ALL);
        step(1);
        chk("reset_held", pk(8'hFF, 8'hFF, 3'd0, 1'b0), CARE_ALL);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("idle_en0", pk(8'hFF, 8'hFF, 3'd0, 1'b0), CARE_ALL);
        end

        // Table-driven directed vectors.
        foreach (vecs[i]) begin
            start(vecs[i].mask);
            step(vecs[i].k);
            chk($sformatf("vec%0d_m%h_k%0d", i, vecs[i].mask, vecs[i].k),
                pk(vecs[i].seg, vecs[i].an, vecs[i].cur, vecs[i].ft), CARE_ALL);
        end

        // A seg_in change during SHOW must not show until the next SHOW.
        start(8'h01);
        step(3);
        seg_in[7:0] = 8'hAA;
        step(1);
        chk("frozen_mid_show", pk(8'h10, 8'hFE, 3'd0, 1'b0), CARE_ALL);
        step(2);
        chk("single_wrap_tick", pk(8'hFF, 8'hFF, 3'd0, 1'b1), CARE_ALL);
        step(2);
        chk("new_pattern_next_show", pk(8'hAA, 8'hFE, 3'd0, 1'b0), CARE_ALL);
        seg_in = seg_def;

        // Dropping en mid-SHOW forces idle outputs. Re-enabling with mask 0x20 restarts at digit 5.
        start(8'hFF);
        step(3);
        en = 1'b0;
        step(1);
        chk("en_drop", pk(8'hFF, 8'hFF, 3'd0, 1'b0), CARE_NOCUR);
        step(2);
        chk("en_drop_hold", pk(8'hFF, 8'hFF, 3'd0, 1'b0), CARE_NOCUR);
        digit_mask = 8'h20;
        en = 1'b1;
        step(1);
        chk("reen_blank", pk(8'hFF, 8'hFF, 3'd5, 1'b0), CARE_ALL);
        step(2);
        chk("reen_show", pk(8'h15, 8'hDF, 3'd5, 1'b0), CARE_ALL);
        step(4);
        chk("reen_tick", pk(8'hFF, 8'hFF, 3'd5, 1'b1), CARE_ALL);

        // Clearing the mask mid-SHOW lets that SHOW finish, then the DUT idles and restarts later.
        start(8'h01);
        step(3);
        digit_mask = 8'h00;
        step(1);
        chk("mask0_show_finishes", pk(8'h10, 8'hFE, 3'd0, 1'b0), CARE_ALL);
        step(2);
        chk("mask0_idle", pk(8'hFF, 8'hFF, 3'd0, 1'b0), CARE_NOCUR);
        step(3);
        chk("mask0_idle_hold", pk(8'hFF, 8'hFF, 3'd0, 1'b0), CARE_NOCUR);
        digit_mask = 8'h02;
        step(1);
        chk("mask_restart_blank", pk(8'hFF, 8'hFF, 3'd1, 1'b0), CARE_ALL);
        step(2);
        chk("mask_restart_show", pk(8'h11, 8'hFD, 3'd1, 1'b0), CARE_ALL);

        // Asserting reset mid-SHOW acts at once, and no partial digit completes afterwards.
        start(8'h04);
        step(3);
        chk("pre_async_show", pk(8'h12, 8'hFB, 3'd2, 1'b0), CARE_ALL);
        reset = 1'b0;
        #1;
        chk("async_reset_immediate", pk(8'hFF, 8'hFF, 3'd0, 1'b0), CARE_ALL);
        step(1);
        reset = 1'b1;
        step(1);
        chk("post_reset_blank", pk(8'hFF, 8'hFF, 3'd2, 1'b0), CARE_ALL);
        step(2);
        chk("post_reset_show", pk(8'h12, 8'hFB, 3'd2, 1'b0), CARE_ALL);

        // Randomized masks and patterns, checked against the reference model.
        for (int it = 0; it < 14; it++) begin
            logic [7:0]  m;
            logic [63:0] s;
            m = (it == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            s = {$urandom, $urandom};
            seg_in = s;
            start(m);
            for (int k = 0; k < 50; k++) begin
                chk($sformatf("rand%0d_m%h_k%0d", it, m, k), model(m, s, k),
                    (m == 8'h00) ? CARE_NOCUR : CARE_ALL);
                step(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
